video_capture: RTL and testbench
================================

Name: video_capture

Overview:
- Write-side counterpart of the display driver: accepts a DE/HS/VS RGB888 video stream and pushes active pixels into the frame-buffer write FIFO.
- Pixels are packed in the same 32-bit word format the display path reads back.
- Provides a frame-load strobe and frame measurement/status so software or a frame-buffer controller can confirm the incoming resolution.
- Sits between a sensor/ISP output and the DDR frame-buffer write FIFO.

Parameters:
- video_h_visible, 1920, expected active pixels per line.
- video_v_visible, 1080, expected active lines per frame.
- video_vsync_pol, 1, 1 = vsync active high, 0 = active low.
- pad_byte, 8'h00, value of wfifo_din[7:0].

Ports:
- pixel_clock  in  1  video/pixel clock; all logic is in this domain.
- reset_n  in  1  asynchronous active-low reset.
- capture_en  in  1  enables capture; sampled at frame boundaries only.
- video_vsync  in  1  input vertical sync, polarity set by video_vsync_pol.
- video_den  in  1  input data enable, active high.
- video_pixel  in  24  input pixel, R[23:16] G[15:8] B[7:0].
- wr_load  out  1  frame-load strobe to the frame-buffer write side.
- wr_clk  out  1  write FIFO clock, equal to pixel_clock.
- wfifo_wren  out  1  write FIFO write enable.
- wfifo_din  out  32  {pixel[23:0], pad_byte}.
- wfifo_full  in  1  write FIFO full.
- frame_done  out  1  one-cycle pulse at the end of each captured frame.
- frame_ok  out  1  last captured frame matched the expected H/V size with no overflow.
- meas_h  out  14  active pixels in the last line of the last frame.
- meas_v  out  14  active lines in the last frame.
- overflow  out  1  sticky within a frame; set if any pixel was dropped because wfifo_full was high.
- frame_cnt  out  16  captured-frame counter.

Behaviour:
- Reset values:
  - All registered outputs are 0; wr_load is 0.
  - State is IDLE.
  - wr_clk is a pure assign of pixel_clock and is not reset.
- Stage 1: register vsync, den and pixel. Normalise vsync: vs = video_vsync_pol ? vsync : ~vsync.
- vs_start is asserted when vs rises between stage-1 samples. den_fall is asserted when den falls between stage-1 samples.
- wr_load equals the stage-1 normalised vs, registered, giving 2 cycles latency from the pins. It toggles in every state.
- FSM:
  - IDLE: on vs_start with capture_en=1, go to ARM.
  - ARM: clear x_cnt, y_cnt, line_err, overflow. On the first stage-1 den, go to CAPTURE.
  - CAPTURE: on vs_start, close the frame:
    - Latch meas_v = y_cnt.
    - Set frame_ok = (y_cnt == video_v_visible) & ~line_err & ~overflow.
    - Pulse frame_done.
    - Increment frame_cnt; it wraps at 16'hFFFF -> 0.
    - If capture_en=1, go to ARM; otherwise go to IDLE.
- The first partial frame after reset or enable is never written: writes occur only in ARM/CAPTURE, which are entered only after vs_start.
- Counters in ARM/CAPTURE:
  - x_cnt increments on each stage-1 den cycle.
  - On den_fall: set meas_h = x_cnt; set line_err if x_cnt != video_h_visible; increment y_cnt; clear x_cnt.
  - x_cnt and y_cnt saturate at 14'h3FFF and do not wrap.
- Write path:
  - Stage 2 registers wfifo_wren = den1 & (state==ARM | state==CAPTURE) & ~wfifo_full.
  - wfifo_din = {pixel1, pad_byte}.
  - Latency is 2 cycles pin-to-FIFO.
- wfifo_full:
  - Sampled in the same cycle as the write decision.
  - If den1 & full, the pixel is dropped and overflow is set.
  - overflow clears only in ARM.
- Simultaneous vs_start and den in the same cycle: the pixel belongs to the new frame.
  - Close the old frame first.
  - The new frame's x_cnt starts at 1.
- capture_en deasserted mid-frame: the current frame completes normally.
- reset_n assertion mid-frame:
  - All outputs go to 0 immediately (asynchronously).
  - After release, the block resyncs on the next vs_start.

Decomposition:
- Shared package video_pkg holds:
  - the state enum (IDLE, ARM, CAPTURE);
  - the 14-bit coordinate width constant;
  - the 32-bit FIFO word layout (pixel msb 31, pad 7:0).
- One sub-module, video_edge_det: registers a 1-bit signal and emits rise/fall pulses. It is instantiated for vs and den.

Test Plan:
- 1920x1080 timing (2200x1125 totals, vsync 5 lines) with capture_en=1 for 3 frames:
  - frame 1 produces no writes;
  - frames 2-3 each produce 2,073,600 wfifo_wren pulses;
  - frame_done pulses 2 times, with meas_h=1920, meas_v=1080, frame_ok=1, frame_cnt=2.
- Pixel ramp 24'h000001 upward: the first wfifo_din of a frame is 32'h00000100, appearing 2 cycles after the first den.
- Hold wfifo_full=1 for 10 cycles mid-line:
  - exactly 10 pixels are dropped;
  - overflow=1 until the next ARM;
  - frame_ok=0 for that frame.
- One short line (1919 pixels) in a frame: meas_h reports the last line's size, line_err sets, frame_ok=0; the following clean frame gives frame_ok=1.
- video_vsync_pol=0 with inverted sync: results are identical to the first scenario; wr_load follows the normalised (active-high) vsync.
- Drop capture_en mid-frame, then assert reset_n=0 mid-line:
  - the current frame completes and the FSM goes to IDLE with no further writes;
  - on reset, wfifo_wren=0 at once and frame_cnt=0.

Source files
------------

// File: rtl/video_pkg.sv
`default_nettype none
// ============================================================================
// video_pkg : shared types and constants for the video capture path
// Rev 1.0
// ============================================================================
package video_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARM     = 2'd1,
        ST_CAPTURE = 2'd2
    } state_t;

    localparam int c_COORD_W = 14;
    localparam logic [c_COORD_W-1:0] c_COORD_MAX = '1;

    // Frame-buffer word: pixel in the upper three bytes, pad byte at the bottom
    localparam int c_WORD_W       = 32;
    localparam int c_WORD_PIX_MSB = 31;
    localparam int c_WORD_PIX_LSB = 8;
    localparam int c_WORD_PAD_MSB = 7;
    localparam int c_WORD_PAD_LSB = 0;

    function automatic logic [c_COORD_W-1:0] sat_inc(input logic [c_COORD_W-1:0] v);
        return (v == c_COORD_MAX) ? v : v + c_COORD_W'(1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/video_edge_det.sv
`default_nettype none
// ============================================================================
// video_edge_det : registers a 1-bit signal and flags its rise/fall
// Rev 1.0
// ============================================================================
module video_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q,
    output logic o_rise,
    output logic o_fall
);

    logic r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= 1'b0;
        end else begin
            r_q <= i_d;
        end
    end

    assign o_q    = r_q;
    assign o_rise = i_d & ~r_q;
    assign o_fall = ~i_d & r_q;

endmodule
`default_nettype wire

// File: rtl/video_capture.sv
`default_nettype none
// ============================================================================
// video_capture : DE/VS RGB888 stream to frame-buffer write FIFO, with
//                 per-frame size measurement and status.   Rev 1.0
// ============================================================================
module video_capture
    import video_pkg::*;
#(
    parameter int unsigned VIDEO_H_VISIBLE = 1920,
    parameter int unsigned VIDEO_V_VISIBLE = 1080,
    parameter bit          VIDEO_VSYNC_POL = 1'b1,
    parameter logic [7:0]  PAD_BYTE        = 8'h00
) (
    input  logic                pixel_clock,
    input  logic                reset_n,
    input  logic                capture_en,
    input  logic                video_vsync,
    input  logic                video_den,
    input  logic [23:0]         video_pixel,
    output logic                wr_load,
    output logic                wr_clk,
    output logic                wfifo_wren,
    output logic [c_WORD_W-1:0] wfifo_din,
    input  logic                wfifo_full,
    output logic                frame_done,
    output logic                frame_ok,
    output logic [13:0]         meas_h,
    output logic [13:0]         meas_v,
    output logic                overflow,
    output logic [15:0]         frame_cnt
);

    localparam logic [c_COORD_W-1:0] c_H_VIS = c_COORD_W'(VIDEO_H_VISIBLE);
    localparam logic [c_COORD_W-1:0] c_V_VIS = c_COORD_W'(VIDEO_V_VISIBLE);

    logic                r_vs1;
    logic                r_den1;
    logic [23:0]         r_pixel1;
    logic                w_vs_q;
    logic                w_vs_start;
    logic                w_vs_fall_unused;
    logic                w_den_q_unused;
    logic                w_den_rise_unused;
    logic                w_den_fall;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                w_frame_close;
    logic                w_arm_entry;
    logic                w_active;

    logic [c_COORD_W-1:0] r_x_cnt;
    logic [c_COORD_W-1:0] r_y_cnt;
    logic                 r_line_err;
    logic                 r_overflow;
    logic [c_COORD_W-1:0] r_meas_h;
    logic [c_COORD_W-1:0] r_meas_v;
    logic                 r_frame_ok;
    logic                 r_frame_done;
    logic [15:0]          r_frame_cnt;
    logic                 r_wren;
    logic [c_WORD_W-1:0]  r_din;
    logic [c_WORD_W-1:0]  w_word;

    // Stage 1: vsync is normalised to active-high before registering
    always_ff @(posedge pixel_clock or negedge reset_n) begin
        if (!reset_n) begin
            r_vs1    <= 1'b0;
            r_den1   <= 1'b0;
            r_pixel1 <= '0;
        end else begin
            r_vs1    <= VIDEO_VSYNC_POL ? video_vsync : ~video_vsync;
            r_den1   <= video_den;
            r_pixel1 <= video_pixel;
        end
    end

    video_edge_det u_vs_edge (
        .clk    (pixel_clock),
        .rst_n  (reset_n),
        .i_d    (r_vs1),
        .o_q    (w_vs_q),
        .o_rise (w_vs_start),
        .o_fall (w_vs_fall_unused)
    );

    video_edge_det u_den_edge (
        .clk    (pixel_clock),
        .rst_n  (reset_n),
        .i_d    (r_den1),
        .o_q    (w_den_q_unused),
        .o_rise (w_den_rise_unused),
        .o_fall (w_den_fall)
    );

    always_ff @(posedge pixel_clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_frame_close = 1'b0;
        w_arm_entry   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_vs_start && capture_en) begin
                    w_state_nxt = ST_ARM;
                    w_arm_entry = 1'b1;
                end
            end
            ST_ARM: begin
                if (w_vs_start) begin
                    w_state_nxt = capture_en ? ST_ARM : ST_IDLE;
                    w_arm_entry = capture_en;
                end else if (r_den1) begin
                    w_state_nxt = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                if (w_vs_start) begin
                    w_frame_close = 1'b1;
                    w_state_nxt   = capture_en ? ST_ARM : ST_IDLE;
                    w_arm_entry   = capture_en;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_active = (r_state == ST_ARM) || (r_state == ST_CAPTURE);

    always_ff @(posedge pixel_clock or negedge reset_n) begin
        if (!reset_n) begin
            r_x_cnt      <= '0;
            r_y_cnt      <= '0;
            r_line_err   <= 1'b0;
            r_overflow   <= 1'b0;
            r_meas_h     <= '0;
            r_meas_v     <= '0;
            r_frame_ok   <= 1'b0;
            r_frame_done <= 1'b0;
            r_frame_cnt  <= '0;
        end else begin
            r_frame_done <= w_frame_close;
            if (w_frame_close) begin
                r_meas_v    <= r_y_cnt;
                r_frame_ok  <= (r_y_cnt == c_V_VIS) & ~r_line_err & ~r_overflow;
                r_frame_cnt <= r_frame_cnt + 16'd1;
            end
            if (w_arm_entry) begin
                // A pixel coincident with vs_start is the new frame's first pixel
                r_x_cnt    <= (r_den1 && w_active) ? c_COORD_W'(1) : '0;
                r_y_cnt    <= '0;
                r_line_err <= 1'b0;
                r_overflow <= r_den1 & w_active & wfifo_full;
            end else if (w_active) begin
                if (r_den1) begin
                    r_x_cnt <= sat_inc(r_x_cnt);
                end
                if (w_den_fall) begin
                    r_meas_h <= r_x_cnt;
                    if (r_x_cnt != c_H_VIS) begin
                        r_line_err <= 1'b1;
                    end
                    r_y_cnt <= sat_inc(r_y_cnt);
                    r_x_cnt <= '0;
                end
                if (r_den1 && wfifo_full) begin
                    r_overflow <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_word                               = '0;
        w_word[c_WORD_PIX_MSB:c_WORD_PIX_LSB] = r_pixel1;
        w_word[c_WORD_PAD_MSB:c_WORD_PAD_LSB] = PAD_BYTE;
    end

    // Stage 2: the full flag is sampled in the same cycle as the write decision
    always_ff @(posedge pixel_clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wren <= 1'b0;
            r_din  <= '0;
        end else begin
            r_wren <= r_den1 & w_active & ~wfifo_full;
            r_din  <= w_word;
        end
    end

    assign wr_clk     = pixel_clock;
    assign wr_load    = w_vs_q;
    assign wfifo_wren = r_wren;
    assign wfifo_din  = r_din;
    assign frame_done = r_frame_done;
    assign frame_ok   = r_frame_ok;
    assign meas_h     = r_meas_h;
    assign meas_v     = r_meas_v;
    assign overflow   = r_overflow;
    assign frame_cnt  = r_frame_cnt;

endmodule
`default_nettype wire

// File: tb/tb_video_capture.sv
`default_nettype none
// ============================================================================
// tb_video_capture : randomised frames against a frame/line-level model,
//                    run on an active-high and an active-low vsync instance.
// ============================================================================
module tb_video_capture;

    localparam int H        = 16;
    localparam int V        = 6;
    localparam int HT       = 24;
    localparam int VS_LINES = 2;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        cap_en;
    logic        vsync;
    logic        den;
    logic        full;
    logic [23:0] pix;
    wire         vsync_n = ~vsync;

    wire [1:0]   wr_load, wr_clk, wren, fdone, fok, ovf;
    wire [31:0]  din  [2];
    wire [13:0]  mh   [2];
    wire [13:0]  mv   [2];
    wire [15:0]  fcnt [2];

    video_capture #(.VIDEO_H_VISIBLE(H), .VIDEO_V_VISIBLE(V), .VIDEO_VSYNC_POL(1'b1), .PAD_BYTE(8'h00)) u_dut_p (
        .pixel_clock(clk), .reset_n(rst_n), .capture_en(cap_en), .video_vsync(vsync),
        .video_den(den), .video_pixel(pix), .wr_load(wr_load[0]), .wr_clk(wr_clk[0]),
        .wfifo_wren(wren[0]), .wfifo_din(din[0]), .wfifo_full(full), .frame_done(fdone[0]),
        .frame_ok(fok[0]), .meas_h(mh[0]), .meas_v(mv[0]), .overflow(ovf[0]), .frame_cnt(fcnt[0]));

    video_capture #(.VIDEO_H_VISIBLE(H), .VIDEO_V_VISIBLE(V), .VIDEO_VSYNC_POL(1'b0), .PAD_BYTE(8'h00)) u_dut_n (
        .pixel_clock(clk), .reset_n(rst_n), .capture_en(cap_en), .video_vsync(vsync_n),
        .video_den(den), .video_pixel(pix), .wr_load(wr_load[1]), .wr_clk(wr_clk[1]),
        .wfifo_wren(wren[1]), .wfifo_din(din[1]), .wfifo_full(full), .frame_done(fdone[1]),
        .frame_ok(fok[1]), .meas_h(mh[1]), .meas_v(mv[1]), .overflow(ovf[1]), .frame_cnt(fcnt[1]));

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // ---------------- reference model state ----------------
    typedef struct { int cyc; logic [31:0] d; } wr_t;
    typedef struct { int cyc; logic [13:0] h; logic [13:0] v; logic ok; logic [15:0] cnt; } fr_t;

    wr_t  wq[$];
    fr_t  fq[$];
    int   widx [2];
    int   fidx [2];
    bit   exp_wl [0:16383];

    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    bit          m_cap, m_seen, m_err, prev_vs, prev_de, pend_drop;
    int          m_lines, m_last_len, m_drops, m_run, rst_hold;
    logic [15:0] m_fcnt;
    logic [23:0] ramp_val;

    task automatic drive(input logic vs, input logic de, input logic [23:0] p, input logic drop);
        @(posedge clk); #1;
        vsync = vs; den = de; pix = p;
        full = pend_drop;
        pend_drop = de & drop;
        if (cyc + 2 < 16384) exp_wl[cyc+2] = rst_n & vs;
        if (vs && !prev_vs && rst_n) begin
            if (m_cap && m_seen) begin
                m_fcnt++;
                fq.push_back('{cyc + 2, 14'(m_last_len), 14'(m_lines),
                               (m_lines == V) && !m_err && (m_drops == 0), m_fcnt});
            end
            m_cap = cap_en; m_seen = 0; m_lines = 0; m_err = 0; m_drops = 0; m_run = 0;
        end
        if (m_cap) begin
            if (de) begin
                m_seen = 1;
                m_run++;
                if (drop) m_drops++;
                else wq.push_back('{cyc + 2, {p, 8'h00}});
            end else if (prev_de) begin
                m_last_len = m_run;
                m_lines++;
                if (m_run != H) m_err = 1;
                m_run = 0;
            end
        end
        prev_vs = vs; prev_de = de;
    endtask

    task automatic do_reset();
        for (int k = 0; k < 2; k++) chk("wren_before_rst", wren[k], 1'b1);
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("wren_async_rst", wren[k], 1'b0);
            chk("fcnt_async_rst", fcnt[k], 16'd0);
            chk("wrload_async_rst", wr_load[k], 1'b0);
        end
        exp_wl[cyc] = 0; exp_wl[cyc+1] = 0; exp_wl[cyc+2] = 0;
        m_cap = 0; m_fcnt = 0;
        for (int k = 0; k < 2; k++) begin
            widx[k] = wq.size();
            fidx[k] = fq.size();
        end
        rst_hold = 3;
    endtask

    task automatic drive_frame(input int pre, input int short_line, input int drop_line,
                               input int drop_pos, input int drop_n, input bit ramp,
                               input int en_off_line, input int rst_line);
        int          a, len;
        logic        de, vs, dr;
        logic [23:0] p;
        for (int l = 0; l < pre + V + 1; l++) begin
            a = l - pre;
            for (int c = 0; c < HT; c++) begin
                len = (a == short_line) ? H - 1 : H;
                de  = (a >= 0) && (a < V) && (c < len);
                vs  = (l * HT + c) < VS_LINES * HT;
                dr  = (a == drop_line) && (c >= drop_pos) && (c < drop_pos + drop_n);
                p   = ramp ? ramp_val : 24'($urandom);
                if (ramp && de) ramp_val = ramp_val + 24'd1;
                drive(vs, de, p, dr);
                if (l == en_off_line && c == 0) cap_en = 1'b0;
                if (a >= 0 && a < V && c == HT - 1 && m_cap && rst_n)
                    for (int k = 0; k < 2; k++) chk("overflow", ovf[k], m_drops != 0);
                if (l == rst_line && c == 8) do_reset();
                else if (rst_hold > 0) begin
                    rst_hold--;
                    if (rst_hold == 0) rst_n = 1'b1;
                end
            end
        end
    endtask

    // ---------------- output monitor ----------------
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (cyc >= 2 && cyc < 16384) chk("wr_load", wr_load[k], exp_wl[cyc]);
            if (wren[k]) begin
                if (widx[k] < wq.size()) begin
                    chk("wr_cycle", cyc, wq[widx[k]].cyc);
                    chk("wr_din", din[k], wq[widx[k]].d);
                    widx[k]++;
                end else chk("wr_spurious", wren[k], 1'b0);
            end else if (widx[k] < wq.size() && wq[widx[k]].cyc == cyc) begin
                chk("wr_missing", wren[k], 1'b1);
                widx[k]++;
            end
            if (fdone[k]) begin
                if (fidx[k] < fq.size()) begin
                    chk("fd_cycle", cyc, fq[fidx[k]].cyc);
                    chk("meas_h", mh[k], fq[fidx[k]].h);
                    chk("meas_v", mv[k], fq[fidx[k]].v);
                    chk("frame_ok", fok[k], fq[fidx[k]].ok);
                    chk("frame_cnt", fcnt[k], fq[fidx[k]].cnt);
                    fidx[k]++;
                end else chk("fd_spurious", fdone[k], 1'b0);
            end else if (fidx[k] < fq.size() && fq[fidx[k]].cyc == cyc) begin
                chk("fd_missing", fdone[k], 1'b1);
                fidx[k]++;
            end
        end
    end

    initial begin
        rst_n = 1'b0; cap_en = 1'b1; vsync = 1'b0; den = 1'b0; full = 1'b0; pix = '0;
        m_cap = 0; m_seen = 0; m_err = 0; prev_vs = 0; prev_de = 0; pend_drop = 0;
        m_lines = 0; m_last_len = 0; m_drops = 0; m_run = 0; rst_hold = 0; m_fcnt = 0;
        ramp_val = 24'd1;
        widx[0] = 0; widx[1] = 0; fidx[0] = 0; fidx[1] = 0;

        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("rst_wren", wren[k], 1'b0);
            chk("rst_din", din[k], 32'h0);
            chk("rst_frame_done", fdone[k], 1'b0);
            chk("rst_frame_ok", fok[k], 1'b0);
            chk("rst_meas_h", mh[k], 14'h0);
            chk("rst_meas_v", mv[k], 14'h0);
            chk("rst_overflow", ovf[k], 1'b0);
            chk("rst_frame_cnt", fcnt[k], 16'h0);
            chk("rst_wr_load", wr_load[k], 1'b0);
            chk("wr_clk_follows", wr_clk[k], clk);
        end
        rst_n = 1'b1;

        // Partial frame before the first vsync: must never be written
        for (int l = 0; l < 3; l++)
            for (int c = 0; c < HT; c++) drive(1'b0, c < H, 24'($urandom), 1'b0);

        ramp_val = 24'd1;
        drive_frame(2, -1, -1, 0, 0, 1'b1, -1, -1);                       // ramp frame
        drive_frame(2, -1, -1, 0, 0, 1'b0, -1, -1);                       // clean random
        drive_frame(2, -1, $urandom_range(0, V - 1), $urandom_range(0, H - 10), 10, 1'b0, -1, -1);
        drive_frame(2, $urandom_range(0, V - 1), -1, 0, 0, 1'b0, -1, -1); // one short line
        drive_frame(0, -1, -1, 0, 0, 1'b0, -1, -1);                       // den coincident with vsync
        drive_frame(2, -1, -1, 0, 0, 1'b0, 5, -1);                        // capture_en dropped mid-frame
        drive_frame(2, -1, -1, 0, 0, 1'b0, -1, -1);                       // idle frame
        cap_en = 1'b1;
        drive_frame(2, -1, -1, 0, 0, 1'b0, -1, 4);                        // reset mid-line
        drive_frame(2, -1, -1, 0, 0, 1'b0, -1, -1);                       // resync after reset
        cap_en = 1'b0;
        drive_frame(2, -1, -1, 0, 0, 1'b0, -1, -1);                       // closes the last frame
        repeat (4) drive(1'b0, 1'b0, 24'h0, 1'b0);

        for (int k = 0; k < 2; k++) begin
            chk("writes_seen", widx[k], wq.size());
            chk("frames_seen", fidx[k], fq.size());
            chk("frame_cnt_end", fcnt[k], m_fcnt);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
